// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial pattern-detection blocks.
//   PAT_DEFAULT  : pattern loaded at reset when no override is given
//                  (MSB is the first bit received)
//   ovl_mode_e   : encoding of the overlap-mode input
// -----------------------------------------------------------------------------
package seq_pkg;

    localparam logic [3:0] PAT_DEFAULT = 4'b1011;

    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_mode_e;

endpackage

// File: rtl/seq_hist_sreg.sv
// -----------------------------------------------------------------------------
// seq_hist_sreg
// History shift register plus a saturating count of how many valid bits it
// holds.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   shift_en        shift din into the history this edge
//   din             serial data bit
//   flush           empty the history (wins over shift_en)
//   hist [PAT_W]    last PAT_W bits, newest in bit 0
//   fill            number of valid history bits, 0..PAT_W
// -----------------------------------------------------------------------------
module seq_hist_sreg #(
    parameter int PAT_W = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         shift_en,
    input  logic                         din,
    input  logic                         flush,
    output logic [PAT_W-1:0]             hist,
    output logic [$clog2(PAT_W+1)-1:0]   fill
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_d, hist_q;
    logic [FILL_W-1:0] fill_d, fill_q;

    // Fill saturates at PAT_W so it only ever says "the history is full".
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (flush) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en) begin
            hist_d = {hist_q[PAT_W-2:0], din};
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign hist = hist_q;
    assign fill = fill_q;

endmodule

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Serial pattern detector with a runtime-loadable pattern. It works in
// overlapping or non-overlapping mode. It produces a one-cycle registered
// match pulse and keeps a saturating match count.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   din/din_vld  serial bit and its qualifier
//   overlap      1 = overlapping detection, 0 = non-overlapping
//   pat_load     load pat_in as the new pattern (discards history)
//   pat_in       new pattern, MSB = first bit
//   cnt_clr      clear match_cnt (wins over a same-edge increment)
//   match        one-cycle pulse after the completing bit
//   match_cnt    saturating number of matches
//   fill         valid history bits (debug)
//   pattern      currently active pattern
// -----------------------------------------------------------------------------
module seq_detector_param
    import seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_DEFAULT),
    parameter int               CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         din,
    input  logic                         din_vld,
    input  logic                         overlap,
    input  logic                         pat_load,
    input  logic [PAT_W-1:0]             pat_in,
    input  logic                         cnt_clr,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt,
    output logic [$clog2(PAT_W+1)-1:0]   fill,
    output logic [PAT_W-1:0]             pattern
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_NEAR = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-1:0] hist;
    logic             hit;
    logic             flush;

    logic             match_d, match_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [PAT_W-1:0] pattern_d, pattern_q;

    // A match is judged on the incoming bit. The history must already hold
    // PAT_W-1 valid bits. A pattern load on the same edge suppresses it.
    assign hit = din_vld && !pat_load &&
                 ({hist[PAT_W-2:0], din} == pattern_q) &&
                 (fill >= FILL_NEAR);

    // In non-overlapping mode a match restarts collection from scratch.
    // Flushing the history as well as fill is harmless: by the time fill
    // allows another match, every compared bit has been shifted in fresh.
    assign flush = pat_load || (hit && (ovl_mode_e'(overlap) == OVL_OFF));

    seq_hist_sreg #(
        .PAT_W (PAT_W)
    ) u_hist (
        .clk      (clk),
        .reset    (reset),
        .shift_en (din_vld),
        .din      (din),
        .flush    (flush),
        .hist     (hist),
        .fill     (fill)
    );

    // The clear takes precedence, so a match on the clearing edge is not
    // counted. The counter sticks at all-ones instead of wrapping.
    always_comb begin
        match_d   = hit;
        pattern_d = pat_load ? pat_in : pattern_q;
        cnt_d     = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            match_q   <= 1'b0;
            cnt_q     <= '0;
            pattern_q <= PAT_RST;
        end else begin
            match_q   <= match_d;
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
        end
    end

    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign pattern   = pattern_q;

endmodule
